// File: rtl/parity_pkg.sv
// Shared types and elaboration helpers for the streaming parity block.
package parity_pkg;

  typedef enum logic {
    IDLE,
    OPEN
  } acc_state_t;

  function automatic int clog_fanin(input int width, input int fanin);
    int w;
    int s;
    w = width;
    s = 0;
    while (w > 1) begin
      w = (w + fanin - 1) / fanin;
      s++;
    end
    return s;
  endfunction

  // Bus width seen at the input of reduction stage k
  function automatic int stage_w(input int width, input int fanin,
                                 input int k);
    int w;
    w = width;
    for (int i = 0; i < k; i++) begin
      w = (w + fanin - 1) / fanin;
    end
    return w;
  endfunction

endpackage

// File: rtl/xor_reduce_stage.sv
// One registered XOR level with valid/ready and last/odd sidebands.
module xor_reduce_stage
  import parity_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int FANIN = 4,
  localparam int OUT_W = (IN_W + FANIN - 1) / FANIN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  input  logic             in_odd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             out_odd
);

  localparam int PAD_W = OUT_W * FANIN;

  logic [PAD_W-1:0] padded;
  logic [OUT_W-1:0] red;

  // Missing leaves are zero, so they never disturb the parity
  always_comb begin
    padded = '0;
    padded[IN_W-1:0] = in_data;
    red = '0;
    for (int i = 0; i < OUT_W; i++) begin
      red[i] = ^padded[i*FANIN +: FANIN];
    end
  end

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_odd   <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      out_data  <= red;
      out_last  <= in_last;
      out_odd   <= in_odd;
    end
  end

endmodule

// File: rtl/parity_stream_acc.sv
// Pipelined per-packet parity: XOR reduction tree, packet accumulator
// and a registered result slot with full backpressure.
module parity_stream_acc
  import parity_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FANIN  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_odd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_parity,
  output logic [CNT_W-1:0]  out_beats,
  output logic              out_overflow
);

  localparam int S = clog_fanin(DATA_W, FANIN);

  logic [S:0] st_v;
  logic [S:0] st_rdy;
  logic [S:0] st_last;
  logic [S:0] st_odd;

  assign st_v[0]    = in_valid;
  assign st_last[0] = in_last;
  assign st_odd[0]  = in_odd;
  assign in_ready   = st_rdy[0];

  genvar k;
  for (k = 0; k < S; k++) begin : g_stage
    localparam int IW = stage_w(DATA_W, FANIN, k);
    localparam int OW = stage_w(DATA_W, FANIN, k + 1);
    logic [IW-1:0] din;
    logic [OW-1:0] dout;
    if (k == 0) begin : g_first
      assign din = in_data;
    end else begin : g_next
      assign din = g_stage[k-1].dout;
    end
    xor_reduce_stage #(
      .IN_W (IW),
      .FANIN(FANIN)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (st_v[k]),
      .in_ready (st_rdy[k]),
      .in_data  (din),
      .in_last  (st_last[k]),
      .in_odd   (st_odd[k]),
      .out_valid(st_v[k+1]),
      .out_ready(st_rdy[k+1]),
      .out_data (dout),
      .out_last (st_last[k+1]),
      .out_odd  (st_odd[k+1])
    );
  end

  logic fin_par;
  logic fin_v;
  logic fin_last;
  logic fin_odd;
  logic acc_take;
  logic absorb;

  assign fin_par  = g_stage[S-1].dout[0];
  assign fin_v    = st_v[S];
  assign fin_last = st_last[S];
  assign fin_odd  = st_odd[S];

  // A last beat needs a free result slot; other beats never stall
  assign acc_take  = !fin_last || !out_valid || out_ready;
  assign st_rdy[S] = acc_take;
  assign absorb    = fin_v && acc_take;

  acc_state_t       state_q, state_d;
  logic             acc_q, acc_d;
  logic             mode_q, mode_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             emit;
  logic             res_par;
  logic             res_ovf;
  logic [CNT_W-1:0] res_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    res_par = 1'b0;
    res_ovf = 1'b0;
    res_cnt = '0;
    if (absorb) begin
      unique case (state_q)
        IDLE: begin
          acc_d   = fin_par;
          mode_d  = fin_odd;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(1);
          state_d = OPEN;
        end
        OPEN: begin
          acc_d = acc_q ^ fin_par;
          if (cnt_q == '1) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
      if (fin_last) begin
        emit    = 1'b1;
        res_par = acc_d ^ mode_d;
        res_ovf = ovf_d;
        res_cnt = cnt_d;
        state_d = IDLE;
        acc_d   = 1'b0;
        mode_d  = 1'b0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_parity   <= 1'b0;
      out_beats    <= '0;
      out_overflow <= 1'b0;
    end else if (emit) begin
      out_valid    <= 1'b1;
      out_parity   <= res_par;
      out_beats    <= res_cnt;
      out_overflow <= res_ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/parity_stream_acc.md
# parity_stream_acc

Parametrised, pipelined parity generator for streamed multi-beat packets, the next generation of the team's flat 16-input combinational parity benchmark. Each accepted beat is reduced by a registered XOR tree. Per-beat parities are accumulated across a packet delimited by `in_last`, and one parity result per packet is emitted with its beat count. The block sits between a ready/valid producer and a consumer, and provides even/odd mode and full backpressure.

## Interface
- `DATA_W`, 16, data beat width in bits (≥ 2)
- `FANIN`, 4, XOR leaves reduced per pipeline stage (≥ 2)
- `CNT_W`, 16, width of the per-packet beat counter
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  beat present
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`
- `in_data`  in  `DATA_W`  beat payload
- `in_last`  in  1  final beat of packet
- `in_odd`  in  1  parity mode; sampled on the first beat of a packet only
- `out_valid`  out  1  packet result present
- `out_ready`  in  1  result consumed when `out_valid && out_ready`
- `out_parity`  out  1  packet parity bit
- `out_beats`  out  `CNT_W`  number of beats in the packet, saturating
- `out_overflow`  out  1  beat counter saturated during this packet

## Operation
- Reduction pipeline has S = ceil(log_FANIN(DATA_W)) stages. With the defaults, S = 2: 16 inputs reduce to 4, then to 1.
  - Each stage registers its partial XORs together with `last`, `odd` and `valid`.
  - A stage loads when it is empty or when its downstream stage loads in the same cycle.
  - `in_ready` is stage 0's load condition.
- Accumulator FSM:
  - IDLE (no open packet): on a beat, acc = beat parity, cnt = 1, mode latched from the beat's `odd` flag, ovf = 0. Go to OPEN, or to EMIT if the beat is last.
  - OPEN: on a beat, acc ^= beat parity, and cnt increments.
    - If cnt is already 2^CNT_W−1, cnt holds and ovf is set (sticky).
    - A last beat moves the FSM to EMIT.
  - EMIT is not a dwell state. Results are written to the output register in the same cycle the last beat is absorbed, and the FSM returns to IDLE.
- Result value: `out_parity` = acc XOR mode. Mode 0 gives even parity (the bit equals the XOR of all data bits). Mode 1 gives the odd-parity bit.
- The accumulator absorbs a non-last beat unconditionally.
  - It absorbs a last beat only if the output register is empty or drains in the same cycle. Otherwise the last beat stalls in the final reduction stage and backpressure ripples to `in_ready`.
- `in_odd` on non-first beats is ignored.
- Width rules:
  - When DATA_W is not a power of FANIN, missing leaves are tied to 0.
  - `out_beats` is zero-extended; there is no wrap.

## Timing
- Reset (async assert; release synchronous to `clk`):
  - all stage valids = 0, FSM = IDLE, acc = 0, cnt = 0, ovf = 0
  - `out_valid` = 0, `out_parity` = 0, `out_beats` = 0, `out_overflow` = 0
  - `in_ready` = 1 from the first cycle after release
- Latency: S+1 cycles from the handshake of the last beat to `out_valid`, with no stalls. With the defaults this is 3 cycles.
- Throughput: one beat per cycle. Back-to-back single-beat packets give one result per cycle while `out_ready` = 1.
- `out_*` are registered and held stable while `out_valid && !out_ready`.
- Reset mid-packet discards the open packet and all in-flight beats. No partial result is emitted.

## Structure
- Shared package `parity_pkg`:
  - function `clog_fanin(width, fanin)` → stage count
  - FSM state enum {IDLE, OPEN}
- Sub-module `xor_reduce_stage`: parametrised by input width and FANIN. It is one registered XOR level with valid/ready and carries the `last`/`odd` sidebands. It is instantiated S times in a generate loop.
- The top level holds the accumulator FSM and the output register.
- Target size is about 200 lines of RTL.

## Test plan
- Single beat 0x0001, `in_odd` = 0, `in_last` = 1, `out_ready` = 1 → `out_valid` 3 cycles later, parity = 1, beats = 1, overflow = 0. The same beat with `in_odd` = 1 → parity = 0.
- Packet 0x0003, 0x0001, 0x8000 (last), mode 0 (popcount 4) → parity = 0, beats = 3. Changing `in_odd` to 1 on beat 2 has no effect.
- `out_ready` = 0 while 3 single-beat packets 0xFFFF, 0x0007, 0x0000 are streamed → first result held stable (parity 0), `in_ready` drops once the pipeline fills. After `out_ready` = 1, results 0, 1, 0 appear in order with no loss or duplication.
- CNT_W = 4, 17-beat packet of 0x0001, mode 0 → beats = 15, overflow = 1, parity = 1. The next packet reports overflow = 0.
- `rst` pulsed mid-cycle with 2 beats of an open packet in flight → `out_valid` = 0 immediately, no result emitted. A subsequent 1-beat packet 0x0101 yields parity = 0, beats = 1.
- DATA_W = 10, FANIN = 3 (S = 3), random beats and packet lengths 1–8 against a scoreboard → every result matches, with latency 4.
